// File: rtl/pipe_pkg.sv
// Shared defaults, legal ranges and sizing helper for the register pipeline.
// Latency: none (declarations only).
// Backpressure: not applicable.
package pipe_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 64;
    localparam int STAGES_DEF = 3;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 16;

    // Bits needed to hold an occupancy value in 0..stages.
    function automatic int cnt_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/pipe_chain_if.sv
// Valid/ready payload bundle used on both ends of the pipeline.
// Latency: none (wiring only).
// Backpressure: ready flows from slave to master, a beat moves when valid && ready.
interface pipe_chain_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) ();

    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);

endinterface

// File: rtl/pipe_stage.sv
// One pipeline slot: data register, valid bit and the local ready term.
// Latency: 1 cycle from up_valid/up_data to valid/data.
// Backpressure: up_ready = !valid || dn_ready, purely combinational so a full chain streams without bubbles.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             clear,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    input  logic             dn_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    assign up_ready = !valid || dn_ready;

    // Slot update: clear drops the item but keeps the data, hold freezes everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (!hold && up_ready) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// Chain of STAGES valid/ready register slots with stall, flush and an occupancy count.
// Latency: STAGES edges from input accept to output take when downstream is ready.
// Backpressure: out_ready ripples combinationally to in_ready; stall and flush force in_ready and out_valid low.
module pipe_chain
    import pipe_pkg::*;
#(
    parameter  int WIDTH  = WIDTH_DEF,
    parameter  int STAGES = STAGES_DEF,
    localparam int CW     = cnt_w(STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    pipe_chain_if.slave       in_if,
    pipe_chain_if.master      out_if,
    input  logic              stall,
    input  logic              flush,
    output logic [STAGES-1:0] stage_valid,
    output logic [CW-1:0]     count
);

    logic [WIDTH-1:0]  stg_data [STAGES];
    logic [STAGES-1:0] stg_vld;
    logic              rdy      [STAGES+1];
    logic              blocked;
    logic              src_vld;
    logic              acc;
    logic              take;

    // Flush wins over stall: a flush cycle clears valids even while stalled.
    assign blocked    = stall || flush;
    assign src_vld    = in_if.valid && !blocked && !rst;
    assign rdy[STAGES] = out_if.ready && !blocked;

    assign in_if.ready  = rdy[0] && !blocked && !rst;
    assign out_if.valid = stg_vld[STAGES-1] && !blocked;
    assign out_if.data  = stg_data[STAGES-1];
    assign stage_valid  = stg_vld;

    assign acc  = in_if.valid && in_if.ready;
    assign take = out_if.valid && out_if.ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (k == 0) begin : g_head
            assign up_v = src_vld;
            assign up_d = in_if.data;
        end else begin : g_body
            assign up_v = stg_vld[k-1];
            assign up_d = stg_data[k-1];
        end

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk      (clk),
            .rst      (rst),
            .hold     (stall),
            .clear    (flush),
            .up_valid (up_v),
            .up_data  (up_d),
            .up_ready (rdy[k]),
            .dn_ready (rdy[k+1]),
            .valid    (stg_vld[k]),
            .data     (stg_data[k])
        );
    end

    // Occupancy tracks accepts minus takes, so it lands on the same edge as the valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (acc && !take) begin
            count <= count + CW'(1);
        end else if (!acc && take) begin
            count <= count - CW'(1);
        end
    end

endmodule
